// File: rtl/mmcm_drp_reconfig.sv
// DRP initiator for an MMCME2_ADV: runs host batches of masked register writes
// as DRP read-modify-write cycles while holding the MMCM in reset, then releases
// reset and waits for LOCKED.
// Optional build macro: MMCM_DRP_READBACK_EN adds a verify read after each write.
module mmcm_drp_reconfig #(
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int CNT_W        = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_addr,
  input  logic [15:0] req_mask,
  input  logic [15:0] req_data,
  input  logic        req_last,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        mmcm_rst,
  input  logic        mmcm_locked
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RD_REQ    = 4'd1;
  localparam logic [3:0] S_RD_WAIT   = 4'd2;
  localparam logic [3:0] S_WR_REQ    = 4'd3;
  localparam logic [3:0] S_WR_WAIT   = 4'd4;
  localparam logic [3:0] S_HOLD      = 4'd5;
  localparam logic [3:0] S_LOCK_WAIT = 4'd6;
  localparam logic [3:0] S_FAIL      = 4'd7;
`ifdef MMCM_DRP_READBACK_EN
  localparam logic [3:0] S_VF_REQ    = 4'd8;
  localparam logic [3:0] S_VF_WAIT   = 4'd9;
`endif

  localparam logic [CNT_W-1:0] DRDY_LIM = CNT_W'(DRDY_TIMEOUT);
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_TIMEOUT);

  logic [3:0]       state;
  logic [15:0]      mask_q;
  logic [15:0]      data_q;
  logic             last_q;
  logic [15:0]      merged;
  logic [CNT_W-1:0] cnt;

  // merged only changes on the read drdy, i.e. together with the write strobe,
  // so it can drive DI directly and still holds between strobes.
  assign drp_di = merged;

  // Handshake and strobe decode from the current state.
  always_comb begin
    busy      = (state != S_IDLE);
    req_ready = (state == S_IDLE) || (state == S_HOLD);
    drp_dwe   = (state == S_WR_REQ);
    drp_den   = (state == S_RD_REQ) || (state == S_WR_REQ);
`ifdef MMCM_DRP_READBACK_EN
    drp_den   = drp_den || (state == S_VF_REQ);
`endif
  end

  // Batch sequencer: capture, read, merge, write, (verify), lock wait.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= S_IDLE;
      drp_daddr <= '0;
      mask_q    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      merged    <= '0;
      cnt       <= '0;
      mmcm_rst  <= 1'b0;
      error     <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_HOLD: begin
          if (req_valid) begin
            drp_daddr <= req_addr;
            mask_q    <= req_mask;
            data_q    <= req_data;
            last_q    <= req_last;
            mmcm_rst  <= 1'b1;
            if (state == S_IDLE) error <= 1'b0;
            state     <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          cnt   <= '0;
          state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (drp_drdy) begin
            merged <= (drp_do & mask_q) | (data_q & ~mask_q);
            state  <= S_WR_REQ;
          end else if (cnt == DRDY_LIM) begin
            state <= S_FAIL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WR_REQ: begin
          cnt   <= '0;
          state <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (drp_drdy) begin
`ifdef MMCM_DRP_READBACK_EN
            state <= S_VF_REQ;
`else
            if (last_q) begin
              mmcm_rst <= 1'b0;
              cnt      <= '0;
              state    <= S_LOCK_WAIT;
            end else begin
              state <= S_HOLD;
            end
`endif
          end else if (cnt == DRDY_LIM) begin
            state <= S_FAIL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef MMCM_DRP_READBACK_EN
        S_VF_REQ: begin
          cnt   <= '0;
          state <= S_VF_WAIT;
        end
        S_VF_WAIT: begin
          if (drp_drdy) begin
            if ((drp_do ^ merged) != '0) begin
              state <= S_FAIL;
            end else if (last_q) begin
              mmcm_rst <= 1'b0;
              cnt      <= '0;
              state    <= S_LOCK_WAIT;
            end else begin
              state <= S_HOLD;
            end
          end else if (cnt == DRDY_LIM) begin
            state <= S_FAIL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_LOCK_WAIT: begin
          // cnt==0 is the first cycle after release; LOCKED is trusted from cnt>=1.
          if (mmcm_locked && (cnt != '0)) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (cnt == LOCK_LIM) begin
            state <= S_FAIL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FAIL: begin
          error    <= 1'b1;
          mmcm_rst <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench for mmcm_drp_reconfig with a behavioural DRP slave and LOCKED model.
// Build with MMCM_DRP_READBACK_EN to exercise the verify-read variant.
module tb_mmcm_drp_reconfig;

`ifdef MMCM_DRP_READBACK_EN
  localparam int RD_PER_WR = 2;
  localparam int RST_HI_1  = 12;
`else
  localparam int RD_PER_WR = 1;
  localparam int RST_HI_1  = 8;
`endif

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  req_addr = '0;
  logic [15:0] req_mask = '0;
  logic [15:0] req_data = '0;
  logic        req_last = 1'b0;
  logic        busy, done, error;
  logic [6:0]  drp_daddr;
  logic        drp_den, drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        mmcm_rst;
  logic        mmcm_locked;

  mmcm_drp_reconfig #(.DRDY_TIMEOUT(64), .LOCK_TIMEOUT(100), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_mask(req_mask), .req_data(req_data), .req_last(req_last),
    .busy(busy), .done(done), .error(error),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe),
    .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy),
    .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // DRP slave model knobs and register file
  logic [15:0] mem [128];
  int          drdy_delay = 3;
  bit          drdy_en    = 1'b1;
  bit          corrupt    = 1'b0;
  int          pend       = 0;
  bit          p_we       = 1'b0;
  bit          last_wr    = 1'b0;
  logic [6:0]  p_addr     = '0;
  logic [15:0] p_di       = '0;

  initial begin
    drp_drdy = 1'b0;
    drp_do   = '0;
    forever begin
      @(negedge CLK);
      drp_drdy = 1'b0;
      if (!nRST) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          if (p_we) begin
            mem[p_addr] = p_di;
            drp_do = '0;
          end else begin
            drp_do = mem[p_addr];
            if (corrupt && last_wr) drp_do = drp_do ^ 16'h0001;
          end
          last_wr  = p_we;
          drp_drdy = 1'b1;
        end
      end else if (drp_den && drdy_en) begin
        p_we   = drp_dwe;
        p_addr = drp_daddr;
        p_di   = drp_di;
        pend   = drdy_delay;
      end
    end
  end

  // LOCKED model: rises lock_delay cycles after MMCM reset is released
  int lock_delay = 10;
  bit lock_en    = 1'b1;
  int lcnt       = 0;

  initial begin
    mmcm_locked = 1'b0;
    forever begin
      @(negedge CLK);
      if (mmcm_rst) begin
        mmcm_locked = 1'b0;
        lcnt = lock_delay;
      end else if (lock_en && lcnt > 0) begin
        lcnt--;
        if (lcnt == 0) mmcm_locked = 1'b1;
      end
    end
  end

  // Monitor counters (only ever incremented; tests diff against snapshots)
  int rd_strobes = 0, wr_strobes = 0, den_viol = 0, done_cnt = 0;
  int rst_hi = 0, rst_rises = 0, ready_busy = 0, ready_bad = 0, lw_cycles = 0;
  logic [15:0] last_wr_di = '0;
  logic [6:0]  last_wr_addr = '0;
  bit prev_den = 1'b0, prev_rst = 1'b0;

  always @(negedge CLK) begin
    if (nRST) begin
      if (drp_den) begin
        if (drp_dwe) begin
          wr_strobes++;
          last_wr_di   = drp_di;
          last_wr_addr = drp_daddr;
        end else begin
          rd_strobes++;
        end
      end
      if (drp_den && prev_den) den_viol++;
      prev_den = drp_den;
      if (done) done_cnt++;
      if (mmcm_rst) rst_hi++;
      if (mmcm_rst && !prev_rst) rst_rises++;
      prev_rst = mmcm_rst;
      if (busy && req_ready) begin
        ready_busy++;
        if (drp_den || !mmcm_rst) ready_bad++;
      end
      if (busy && !mmcm_rst) lw_cycles++;
    end
  end

  int rd0, wr0, dn0, rh0, rr0, rb0, lw0;

  task automatic snap();
    rd0 = rd_strobes; wr0 = wr_strobes; dn0 = done_cnt; rh0 = rst_hi;
    rr0 = rst_rises;  rb0 = ready_busy; lw0 = lw_cycles;
  endtask

  task automatic send(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d,
                      input logic l);
    int n = 0;
    while (!req_ready && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_addr = a; req_mask = m; req_data = d; req_last = l;
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output int cyc);
    cyc = 0;
    while (busy && cyc < maxc) begin
      @(negedge CLK);
      cyc++;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
    @(negedge CLK);
    #1;
  endtask

  int cyc;
  int n;

  initial begin
    foreach (mem[i]) mem[i] = '0;
    mem[7'h08] = 16'h1C00;
    mem[7'h09] = 16'hABCD;
    mem[7'h14] = 16'h5555;

    // Reset state
    #2 nRST = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_error",     {31'd0, error},     32'd0);
    check("rst_mmcm_rst",  {31'd0, mmcm_rst},  32'd0);
    check("rst_den",       {31'd0, drp_den},   32'd0);
    check("rst_dwe",       {31'd0, drp_dwe},   32'd0);
    check("rst_daddr",     {25'd0, drp_daddr}, 32'd0);
    check("rst_di",        {16'd0, drp_di},    32'd0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Single write: 0x1C00 merged with data 0x0041 under mask 0xF000 -> 0x1041
    snap();
    send(7'h08, 16'hF000, 16'h0041, 1'b1);
    wait_idle(300, cyc);
    check("s_rd_strobes", 32'(rd_strobes - rd0), 32'(RD_PER_WR));
    check("s_wr_strobes", 32'(wr_strobes - wr0), 32'd1);
    check("s_wr_di",      {16'd0, last_wr_di},   32'h1041);
    check("s_wr_addr",    {25'd0, last_wr_addr}, 32'h08);
    check("s_rst_hi",     32'(rst_hi - rh0),     32'(RST_HI_1));
    check("s_done",       32'(done_cnt - dn0),   32'd1);
    check("s_error",      {31'd0, error},        32'd0);
    check("s_mem08",      {16'd0, mem[7'h08]},   32'h1041);

    // Batch of three writes
    snap();
    send(7'h08, 16'hF000, 16'h0041, 1'b0);
    send(7'h09, 16'h00FF, 16'h1200, 1'b0);
    send(7'h14, 16'h0000, 16'h0F0F, 1'b1);
    wait_idle(300, cyc);
    check("b_strobes",    32'((rd_strobes - rd0) + (wr_strobes - wr0)), 32'(3 * (RD_PER_WR + 1)));
    check("b_done",       32'(done_cnt - dn0),   32'd1);
    check("b_rst_rises",  32'(rst_rises - rr0),  32'd1);
    check("b_hold_cyc",   32'(ready_busy - rb0), 32'd2);
    check("b_ready_bad",  32'(ready_bad),        32'd0);
    check("b_mem09",      {16'd0, mem[7'h09]},   32'h12CD);
    check("b_mem14",      {16'd0, mem[7'h14]},   32'h0F0F);
    check("b_error",      {31'd0, error},        32'd0);

    // DRDY never returns after the read strobe
    drdy_en = 1'b0;
    snap();
    send(7'h08, 16'hF000, 16'h0041, 1'b1);
    wait_idle(300, cyc);
    check("t_window",     32'(cyc >= 64 && cyc <= 70), 32'd1);
    check("t_error",      {31'd0, error},        32'd1);
    check("t_mmcm_rst",   {31'd0, mmcm_rst},     32'd0);
    check("t_rd_strobes", 32'(rd_strobes - rd0), 32'd1);
    check("t_wr_strobes", 32'(wr_strobes - wr0), 32'd0);
    check("t_done",       32'(done_cnt - dn0),   32'd0);
    drdy_en = 1'b1;
    snap();
    send(7'h09, 16'hFFFF, 16'h0000, 1'b1);
    check("t_error_clr",  {31'd0, error},        32'd0);
    wait_idle(300, cyc);
    check("t_next_done",  32'(done_cnt - dn0),   32'd1);

    // Lock timeout
    lock_en = 1'b0;
    snap();
    send(7'h14, 16'h0000, 16'h1234, 1'b1);
    wait_idle(400, cyc);
    check("l_error",      {31'd0, error},        32'd1);
    check("l_done",       32'(done_cnt - dn0),   32'd0);
    check("l_cycles",     32'((lw_cycles - lw0) >= 100 && (lw_cycles - lw0) <= 104), 32'd1);
    lock_en = 1'b1;

    // Reset during WR_WAIT
    drdy_delay = 20;
    snap();
    send(7'h08, 16'hFFFF, 16'h0000, 1'b0);
    n = 0;
    while ((wr_strobes - wr0) < 1 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("r_wr_seen",    32'(wr_strobes - wr0), 32'd1);
    repeat (3) @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    check("r_mmcm_rst",   {31'd0, mmcm_rst},     32'd0);
    check("r_den",        {31'd0, drp_den},      32'd0);
    check("r_dwe",        {31'd0, drp_dwe},      32'd0);
    check("r_daddr",      {25'd0, drp_daddr},    32'd0);
    check("r_di",         {16'd0, drp_di},       32'd0);
    check("r_busy",       {31'd0, busy},         32'd0);
    check("r_ready",      {31'd0, req_ready},    32'd1);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    repeat (40) @(negedge CLK);
    check("r_no_strobes", 32'((rd_strobes - rd0) + (wr_strobes - wr0)), 32'd2);
    drdy_delay = 3;

`ifdef MMCM_DRP_READBACK_EN
    // Verify read returns 0x1040 against merged 0x1041
    mem[7'h08] = 16'h1C00;
    corrupt = 1'b1;
    snap();
    send(7'h08, 16'hF000, 16'h0041, 1'b1);
    wait_idle(300, cyc);
    check("v_error",      {31'd0, error},        32'd1);
    check("v_done",       32'(done_cnt - dn0),   32'd0);
    check("v_wr_di",      {16'd0, last_wr_di},   32'h1041);
    corrupt = 1'b0;
`endif

    check("den_back2back", 32'(den_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmcm_drp_reconfig.md
Name: mmcm_drp_reconfig

Overview:
- DRP initiator that drives the dynamic reconfiguration port of an MMCME2_ADV. It sits beside the clock generator in the clock top level.
- Accepts a batch of masked register writes from a host and runs each one as a DRP read-modify-write.
- Holds the MMCM in reset for the whole batch, then releases it and waits for LOCKED.
- Reports done or error per batch.

Parameters:
DRDY_TIMEOUT, 64, cycles to wait for drp_drdy after any DRP strobe before error
LOCK_TIMEOUT, 65535, cycles to wait for mmcm_locked after reset release before error
CNT_W, 16, width of the shared timeout counter; must satisfy 2^CNT_W > max(DRDY_TIMEOUT, LOCK_TIMEOUT)

Ports:
CLK  in  1  clock; also drives the MMCM DCLK
nRST  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  host request accepted when valid&ready
req_addr  in  7  DRP register address
req_mask  in  16  1 = keep the old bit, 0 = take the req_data bit
req_data  in  16  new bit values
req_last  in  1  last write of the batch
busy  out  1  batch in progress
done  out  1  one-cycle pulse when the batch completes and is locked
error  out  1  sticky timeout/verify error flag
drp_daddr  out  7  to MMCM DADDR
drp_den  out  1  to MMCM DEN
drp_dwe  out  1  to MMCM DWE
drp_di  out  16  to MMCM DI
drp_do  in  16  from MMCM DO
drp_drdy  in  1  from MMCM DRDY
mmcm_rst  out  1  to MMCM RST
mmcm_locked  in  1  from MMCM LOCKED

Behaviour:
- Interface: one clock CLK; reset nRST is asynchronous, active-low.
- Reset values: state=IDLE, all outputs 0 except req_ready=1; mmcm_rst=0; error=0; counter=0.
- Reset taken mid-batch abandons the batch immediately and releases mmcm_rst asynchronously. No DRP strobe is issued after reset.

States:
- IDLE: req_ready=1, busy=0. On accept:
  - capture addr, mask, data and last
  - clear error
  - mmcm_rst<=1
  - go to RD_REQ.
- RD_REQ: drp_den=1, drp_dwe=0, drp_daddr=addr for exactly 1 cycle. Clear the counter; go to RD_WAIT.
- RD_WAIT: counter increments each cycle.
  - On drp_drdy: merged <= (drp_do & mask) | (data & ~mask); go to WR_REQ.
  - If counter reaches DRDY_TIMEOUT first: go to FAIL.
- WR_REQ: drp_den=1, drp_dwe=1, drp_di=merged for 1 cycle. Clear the counter; go to WR_WAIT.
- WR_WAIT: on drp_drdy:
  - if last: mmcm_rst<=0 and go to LOCK_WAIT
  - otherwise go to HOLD.
  - Timeout behaves as in RD_WAIT.
- HOLD: req_ready=1 and mmcm_rst stays 1. On accept, capture the request and go to RD_REQ. No timeout.
- LOCK_WAIT: counter increments.
  - On mmcm_locked=1, sampled no earlier than the 2nd cycle after rst release: done=1 for 1 cycle, go to IDLE.
  - If counter reaches LOCK_TIMEOUT first: go to FAIL.
- FAIL: error<=1, mmcm_rst<=0, go to IDLE. No done pulse.

Signal rules:
- busy=1 in every state except IDLE.
- req_ready=1 only in IDLE and HOLD.
- drp_den is never high on two consecutive cycles. It is never reasserted before the matching drdy or a timeout.
- drp_drdy outside RD_WAIT/WR_WAIT is ignored.
- If drdy arrives in the same cycle the counter hits its limit, drdy wins.
- drp_di and drp_daddr hold their last values when den=0.
- mmcm_rst is minimum 4 cycles high per batch, guaranteed by the RD/WR sequence.

Optional Feature:
- Macro: MMCM_DRP_READBACK_EN.
- Defined: after WR_WAIT, a VERIFY_REQ/VERIFY_WAIT pair re-reads the same address. If (drp_do ^ merged) != 0, go to FAIL; otherwise continue as WR_WAIT would. Verify drdy timeouts apply.
- Undefined: no verify states, and the write completes on the write drdy.

Test Plan:
- Single write: addr=0x08, mask=0xF000, data=0x0041, last=1, DO returns 0x1C00 after 3 cycles.
  - Expect a read strobe, then a write strobe with DI=0x1041.
  - mmcm_rst high from accept until write drdy.
  - Locked 10 cycles later -> done pulse, error=0.
- Batch of 3 writes (0x08, 0x09, 0x14; last on the 3rd):
  - mmcm_rst stays high throughout and req_ready=1 only in HOLD.
  - Exactly 6 DRP strobes; done once.
- DRDY never returns after the read strobe with DRDY_TIMEOUT=64:
  - FAIL at counter 64, error=1, mmcm_rst=0, no write strobe.
  - The next accepted request clears error.
- Lock timeout with LOCK_TIMEOUT=100 and locked held 0: error=1 after 100 cycles in LOCK_WAIT, no done.
- nRST asserted during WR_WAIT: mmcm_rst and all DRP outputs go to 0 asynchronously, state=IDLE, no further strobes.
- With MMCM_DRP_READBACK_EN defined, the verify read returns 0x1040 against merged 0x1041 -> error=1, no done.
